add_align: RTL and testbench

- Pipelined align-and-add stage of the floating-point adder; sits directly upstream of add_renorm.
- Accepts two unsigned operands, each an 8-bit exponent plus an 8-bit mantissa. Bit 7 is the explicit leading one; mantissa 0 means zero.
- Aligns the smaller operand to the larger exponent with guard/round/sticky bits and adds the magnitudes.
- Emits a 12-bit mantissa sum (bit 11 = carry) plus the 8-bit exponent of the larger operand, exactly the add_renorm input format.
- Two register stages, valid/ready handshake on both sides.

---
 rtl/fp_pkg.sv | 22 ++
 rtl/add_align_if.sv | 28 ++
 rtl/align_shifter.sv | 26 ++
 rtl/add_align.sv | 118 +++++++++++
 tb/tb_add_align.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point adder definitions: field widths and the operand record.
package fp_pkg;

  localparam int unsigned MANT_W = 8;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned GRS_W  = 3;
  // Mantissa extended with guard/round/sticky bits.
  localparam int unsigned EXT_W  = MANT_W + GRS_W;
  // Extended mantissa plus one carry bit.
  localparam int unsigned SUM_W  = MANT_W + GRS_W + 1;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } operand_t;

  // Append zeroed guard/round/sticky bits below a mantissa.
  function automatic logic [EXT_W-1:0] extend_mant(input logic [MANT_W-1:0] mant);
    return {mant, {GRS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/add_align_if.sv
// Operand-in / sum-out handshake bundle of the align-and-add stage.
interface add_align_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  a_exp;
  logic [MANT_W-1:0] a_mant;
  logic [EXP_W-1:0]  b_exp;
  logic [MANT_W-1:0] b_mant;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  sum_mant;
  logic [EXP_W-1:0]  sum_exp;

  // Producer of operands / consumer of sums.
  modport master (
    output in_valid, a_exp, a_mant, b_exp, b_mant, out_ready,
    input  in_ready, out_valid, sum_mant, sum_exp
  );

  // The align-and-add stage itself.
  modport slave (
    input  in_valid, a_exp, a_mant, b_exp, b_mant, out_ready,
    output in_ready, out_valid, sum_mant, sum_exp
  );

endinterface

// File: rtl/align_shifter.sv
// Combinational right shift of an extended mantissa with sticky collapse into bit 0.
module align_shifter
  import fp_pkg::*;
(
  input  logic [EXT_W-1:0] i_val,
  input  logic [EXP_W-1:0] i_d,
  output logic [EXT_W-1:0] o_val
);

  logic [EXT_W-1:0] w_shifted;
  logic [EXT_W-1:0] w_mask;
  logic             w_sticky;

  // Shift, OR every discarded bit into the LSB; huge shifts leave only the sticky bit.
  always_comb begin
    w_shifted = i_val >> i_d;
    w_mask    = (EXT_W'(1) << i_d) - EXT_W'(1);
    w_sticky  = |(i_val & w_mask);
    if (i_d >= EXP_W'(EXT_W)) begin
      o_val = {{(EXT_W-1){1'b0}}, |i_val};
    end else begin
      o_val = {w_shifted[EXT_W-1:1], w_shifted[0] | w_sticky};
    end
  end

endmodule

// File: rtl/add_align.sv
// Two-stage align-and-add: stage 1 orders operands by exponent, stage 2 aligns and sums.
module add_align
  import fp_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  add_align_if.slave bus
);

  operand_t         w_a;
  operand_t         w_b;
  operand_t         w_big;
  operand_t         w_small;
  logic             w_adv1;
  logic             w_adv2;

  logic             r_s1_valid;
  operand_t         r_s1_big;
  operand_t         r_s1_small;
  logic [EXP_W-1:0] r_s1_d;
  logic             r_s1_big_zero;
  logic             r_s1_small_zero;

  logic             r_s2_valid;
  logic [SUM_W-1:0] r_sum_mant;
  logic [EXP_W-1:0] r_sum_exp;

  logic [EXT_W-1:0] w_big_ext;
  logic [EXT_W-1:0] w_small_ext;
  logic [EXT_W-1:0] w_small_sh;
  logic [SUM_W-1:0] w_sum_mant;
  logic [EXP_W-1:0] w_sum_exp;

  assign w_a = {bus.a_exp, bus.a_mant};
  assign w_b = {bus.b_exp, bus.b_mant};

  // A stage may advance when its successor is empty or draining this cycle.
  assign w_adv2       = !r_s2_valid || bus.out_ready;
  assign w_adv1       = !r_s1_valid || w_adv2;
  assign bus.in_ready = w_adv1;

  assign bus.out_valid = r_s2_valid;
  assign bus.sum_mant  = r_sum_mant;
  assign bus.sum_exp   = r_sum_exp;

  // Pick the operand with the larger exponent; ties keep A as the big one.
  always_comb begin
    if (w_a.exp >= w_b.exp) begin
      w_big   = w_a;
      w_small = w_b;
    end else begin
      w_big   = w_b;
      w_small = w_a;
    end
  end

  // Stage 1 register: ordered operands, exponent gap and zero flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid      <= 1'b0;
      r_s1_big        <= '0;
      r_s1_small      <= '0;
      r_s1_d          <= '0;
      r_s1_big_zero   <= 1'b0;
      r_s1_small_zero <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_big        <= w_big;
        r_s1_small      <= w_small;
        r_s1_d          <= w_big.exp - w_small.exp;
        r_s1_big_zero   <= (w_big.mant == '0);
        r_s1_small_zero <= (w_small.mant == '0);
      end
    end
  end

  assign w_big_ext   = extend_mant(r_s1_big.mant);
  assign w_small_ext = extend_mant(r_s1_small.mant);

  align_shifter u_shifter (
    .i_val (w_small_ext),
    .i_d   (r_s1_d),
    .o_val (w_small_sh)
  );

  // Aligned sum; a zero operand passes the other one through unshifted.
  always_comb begin
    w_sum_mant = {1'b0, w_big_ext} + {1'b0, w_small_sh};
    w_sum_exp  = r_s1_big.exp;
    if (r_s1_big_zero && r_s1_small_zero) begin
      w_sum_mant = '0;
      w_sum_exp  = '0;
    end else if (r_s1_small_zero) begin
      w_sum_mant = {1'b0, w_big_ext};
      w_sum_exp  = r_s1_big.exp;
    end else if (r_s1_big_zero) begin
      w_sum_mant = {1'b0, w_small_ext};
      w_sum_exp  = r_s1_small.exp;
    end
  end

  // Stage 2 register: result held stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_sum_mant <= '0;
      r_sum_exp  <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum_mant <= w_sum_mant;
        r_sum_exp  <= w_sum_exp;
      end
    end
  end

endmodule

// File: tb/tb_add_align.sv
// Randomized scoreboard bench for add_align with directed corner cases.
module tb_add_align;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_align_if bus ();

  add_align u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [19:0] exp_q[$];
  logic bp_en   = 1'b0;
  int   bp_mode = 0;
  int   bp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  // Reference: align by exponent difference using plain integer arithmetic.
  function automatic logic [19:0] ref_sum(input logic [7:0] ae, am, be, bm);
    int ea, ma, eb, mb, big_e, big_m, sm_m, d, bext, sext, sh, pw;
    ea = int'(ae); ma = int'(am); eb = int'(be); mb = int'(bm);
    if (ma == 0 && mb == 0) return 20'h0;
    if (ma == 0) return {8'(eb), 12'(mb * 8)};
    if (mb == 0) return {8'(ea), 12'(ma * 8)};
    if (ea >= eb) begin
      big_e = ea; big_m = ma; sm_m = mb; d = ea - eb;
    end else begin
      big_e = eb; big_m = mb; sm_m = ma; d = eb - ea;
    end
    bext = big_m * 8;
    sext = sm_m * 8;
    if (d >= 11) begin
      sh = (sm_m != 0) ? 1 : 0;
    end else begin
      pw = 1 << d;
      sh = sext / pw;
      if (sext % pw != 0) sh = sh | 1;
    end
    return {8'(big_e), 12'(bext + sh)};
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  initial begin
    logic        stall_q;
    logic [11:0] held_m;
    logic [7:0]  held_e;
    logic [19:0] e;
    stall_q = 1'b0;
    held_m  = '0;
    held_e  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_mant", 32'(bus.sum_mant), 32'(held_m));
          check("hold_exp", 32'(bus.sum_exp), 32'(held_e));
        end
        check("in_ready", 32'(bus.in_ready), 32'(!(exp_q.size() == 2 && !bus.out_ready)));
        if (exp_q.size() == 0) check("idle_valid", 32'(bus.out_valid), 32'd0);
        if (bus.out_valid && bus.out_ready) begin
          check("spurious_out", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_mant", 32'(bus.sum_mant), 32'(e[11:0]));
            check("sb_exp", 32'(bus.sum_exp), 32'(e[19:12]));
          end
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(ref_sum(bus.a_exp, bus.a_mant, bus.b_exp, bus.b_mant));
        stall_q = bus.out_valid && !bus.out_ready;
        held_m  = bus.sum_mant;
        held_e  = bus.sum_exp;
      end
    end
  end

  // Downstream back-pressure driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        if (bp_mode == 0) bus.out_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
        else bus.out_ready = 1'($urandom_range(0, 1));
        bp_cnt++;
      end
    end
  end

  // Present a pair and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic drive_pair(input logic [7:0] ae, am, be, bm);
    logic ok;
    bus.in_valid = 1'b1;
    bus.a_exp = ae; bus.a_mant = am; bus.b_exp = be; bus.b_mant = bm;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [7:0] ae, am, be, bm,
                          input logic [11:0] wm, input logic [7:0] we);
    bus.out_ready = 1'b1;
    drive_pair(ae, am, be, bm);
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_mant"}, 32'(bus.sum_mant), 32'(wm));
    check({tag, "_exp"}, 32'(bus.sum_exp), 32'(we));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_op(output logic [7:0] e, output logic [7:0] m);
    e = 8'($urandom_range(0, 24));
    m = ($urandom_range(0, 7) == 0) ? 8'h00 : {1'b1, 7'($urandom)};
  endtask

  initial begin
    logic [7:0] ae, am, be, bm;
    bus.in_valid = 1'b0;
    bus.a_exp = '0; bus.a_mant = '0; bus.b_exp = '0; bus.b_mant = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mant", 32'(bus.sum_mant), 32'd0);
    check("rst_exp", 32'(bus.sum_exp), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);

    directed("eq_exp",   8'd10, 8'h80, 8'd10, 8'h80, 12'h800, 8'd10);
    directed("shift",    8'd12, 8'hC0, 8'd10, 8'h80, 12'h700, 8'd12);
    directed("swap",     8'd10, 8'h80, 8'd12, 8'hC0, 12'h700, 8'd12);
    directed("sticky",   8'd9,  8'h80, 8'd5,  8'h81, 12'h441, 8'd9);
    directed("gap15",    8'd20, 8'h80, 8'd5,  8'h81, 12'h401, 8'd20);
    directed("gap8",     8'd13, 8'h80, 8'd5,  8'hFF, 12'h407, 8'd13);
    directed("a_zero",   8'd30, 8'h00, 8'd3,  8'hA0, 12'h500, 8'd3);
    directed("tie_zero", 8'd5,  8'h00, 8'd5,  8'h90, 12'h480, 8'd5);
    directed("both_zero", 8'd7, 8'h00, 8'd9,  8'h00, 12'h000, 8'd0);
    directed("carry",    8'hFF, 8'hFF, 8'hFF, 8'hFF, 12'hFF0, 8'hFF);

    // Fixed 1,0,0,1 back-pressure pattern over a short stream.
    bp_cnt = 0; bp_mode = 0; bp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_op(ae, am); rand_op(be, bm);
      drive_pair(ae, am, be, bm);
    end
    wait_drain("drain_pattern");

    // Random stream with random back-pressure and idle gaps.
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      rand_op(ae, am); rand_op(be, bm);
      if ($urandom_range(0, 5) == 0) be = ae;
      drive_pair(ae, am, be, bm);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain("drain_random");
    bp_en = 1'b0;

    // Reset with both stages occupied.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    drive_pair(8'd4, 8'h90, 8'd2, 8'hC3);
    drive_pair(8'd8, 8'hF0, 8'd8, 8'h88);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    check("full_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_mant", 32'(bus.sum_mant), 32'd0);
    check("mid_rst_exp", 32'(bus.sum_exp), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("no_stale", 32'(bus.out_valid), 32'd0);
    end
    directed("post_rst", 8'd6, 8'h80, 8'd7, 8'h80, 12'h600, 8'd7);
    wait_drain("drain_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
